// File: rtl/byte_data_memory_pkg.sv
// Shared types and helpers for the byte-addressable data memory:
// RISC-V access encodings, handshake FSM states and lane/error decode.
package common;

  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;

  // RISC-V load/store funct3 encodings understood by the memory.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_funct_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_e;

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [LANES-1:0] store_byte_en(input logic [2:0] funct3,
                                                     input logic [1:0] lane);
    logic [LANES-1:0] be;
    be = '0;
    case (funct3)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Store data replicated so every enabled lane sees its right-aligned source.
  function automatic logic [WORD_W-1:0] store_lanes(input logic [2:0]        funct3,
                                                    input logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] lanes;
    case (funct3)
      MEM_B:   lanes = {4{wdata[7:0]}};
      MEM_H:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Misaligned halfword/word, or a funct3 that is not legal for the direction.
  function automatic logic access_error(input logic       is_write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (funct3)
      MEM_B:         err = 1'b0;
      MEM_H:         err = lane[0];
      MEM_W:         err = (lane != 2'b00);
      MEM_BU:        err = is_write;
      MEM_HU:        err = is_write | lane[0];
      default:       err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/byte_data_memory_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it to 32 bits.
module load_align
  import common::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  logic [2:0]        i_funct3,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_lane +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // Extend the selected field according to the access size and signedness.
  always_comb begin
    o_data = '0;
    case (i_funct3)
      MEM_B:   o_data = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  o_data = {24'h0, w_byte};
      MEM_H:   o_data = {{16{w_half[15]}}, w_half};
      MEM_HU:  o_data = {16'h0, w_half};
      MEM_W:   o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable word memory with a valid/ready request channel and a
// held response. One request is in flight at a time: accept in IDLE, hold
// the response in RESP until the consumer takes it.
module byte_data_memory
  import common::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int WORDS = 2 ** (ADDRESS_WIDTH - 2);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("byte_data_memory: DATA_WIDTH must be 32");
  end
  if (ADDRESS_WIDTH < 3 || ADDRESS_WIDTH > 16) begin : g_bad_addr_width
    $error("byte_data_memory: ADDRESS_WIDTH must be in 3..16");
  end

  mem_state_e              r_state;
  mem_state_e              w_state_next;
  logic                    w_accept;
  logic                    w_err;
  logic [ADDRESS_WIDTH-3:0] w_word_idx;
  logic [1:0]              w_lane;
  logic [LANES-1:0]        w_byte_en;
  logic [WORD_W-1:0]       w_wdata_lanes;
  logic [WORD_W-1:0]       w_load_data;

  logic [WORD_W-1:0]       r_mem [WORDS];
  logic [WORD_W-1:0]       r_rd_word;
  logic [1:0]              r_lane;
  logic [2:0]              r_funct3;
  logic                    r_load_ok;
  logic                    r_rsp_err;

  assign w_word_idx    = req_addr[ADDRESS_WIDTH-1:2];
  assign w_lane        = req_addr[1:0];
  assign w_err         = access_error(req_write, req_funct3, w_lane);
  assign w_byte_en     = store_byte_en(req_funct3, w_lane);
  assign w_wdata_lanes = store_lanes(req_funct3, req_wdata);

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = r_rsp_err;

  // State register; reset drops any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: accept in IDLE, release in RESP once the consumer is ready.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Capture response metadata at the accepting edge; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
      r_load_ok <= 1'b0;
      r_lane    <= '0;
      r_funct3  <= '0;
    end else if (w_accept) begin
      r_rsp_err <= w_err;
      r_load_ok <= !req_write && !w_err;
      r_lane    <= w_lane;
      r_funct3  <= req_funct3;
    end
  end

  // Byte-enabled storage with a registered read port, sampled at acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the array and its read register are deliberately not reset so the
    // storage maps onto a RAM macro; unwritten words read as X in simulation.
    if (w_accept) begin
      if (req_write) begin
        if (!w_err) begin
          for (int b = 0; b < LANES; b++) begin
            if (w_byte_en[b]) r_mem[w_word_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
          end
        end
      end else begin
        r_rd_word <= r_mem[w_word_idx];
      end
    end
  end

  load_align u_load_align (
    .i_word   (r_rd_word),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  // Stores, errors and the idle state all present zero data.
  assign rsp_rdata = (rsp_valid && r_load_ok) ? w_load_data : '0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench for byte_data_memory: store/load sizes and extension,
// error responses, response backpressure and asynchronous reset mid-response.
module tb_byte_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  byte_data_memory #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge and wait (bounded) for its acceptance.
  task automatic issue_req(input logic w, input logic [2:0] f3,
                           input logic [9:0] addr, input logic [31:0] wd);
    int n;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rsp_valid_after_accept", {31'b0, rsp_valid}, 32'd1);
  endtask

  // Sample the held response, then take it with a one-edge rsp_ready pulse.
  task automatic complete_rsp(output logic [31:0] rdata, output logic err);
    @(negedge clk);
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("req_ready_after_rsp", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [9:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    issue_req(w, f3, addr, wd);
    complete_rsp(d, e);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] held;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("reset_rsp_rdata", rsp_rdata,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store/load and sized loads with extension.
    xact("sw_10",  1'b1, 3'b010, 10'h010, 32'h8765_4321, 32'h0000_0000, 1'b0);
    xact("lw_10",  1'b0, 3'b010, 10'h010, 32'h0,         32'h8765_4321, 1'b0);
    xact("lb_13",  1'b0, 3'b000, 10'h013, 32'h0,         32'hFFFF_FF87, 1'b0);
    xact("lbu_13", 1'b0, 3'b100, 10'h013, 32'h0,         32'h0000_0087, 1'b0);
    xact("lh_12",  1'b0, 3'b001, 10'h012, 32'h0,         32'hFFFF_8765, 1'b0);
    xact("lhu_10", 1'b0, 3'b101, 10'h010, 32'h0,         32'h0000_4321, 1'b0);
    xact("lb_10",  1'b0, 3'b000, 10'h010, 32'h0,         32'h0000_0021, 1'b0);

    // Partial stores leave unenabled bytes alone.
    xact("sb_11",  1'b1, 3'b000, 10'h011, 32'h1234_56AA, 32'h0,         1'b0);
    xact("lw_sb",  1'b0, 3'b010, 10'h010, 32'h0,         32'h8765_AA21, 1'b0);
    xact("sh_12",  1'b1, 3'b001, 10'h012, 32'hCAFE_BEEF, 32'h0,         1'b0);
    xact("lw_sh",  1'b0, 3'b010, 10'h010, 32'h0,         32'hBEEF_AA21, 1'b0);

    // Error responses: nothing written, zero data.
    xact("sw_mis", 1'b1, 3'b010, 10'h012, 32'h5555_5555, 32'h0,         1'b1);
    xact("lw_chk", 1'b0, 3'b010, 10'h010, 32'h0,         32'hBEEF_AA21, 1'b0);
    xact("ld_011", 1'b0, 3'b011, 10'h010, 32'h0,         32'h0,         1'b1);
    xact("lh_mis", 1'b0, 3'b001, 10'h011, 32'h0,         32'h0,         1'b1);
    xact("sbu_st", 1'b1, 3'b100, 10'h010, 32'h0000_0066, 32'h0,         1'b1);
    xact("lw_chk2",1'b0, 3'b010, 10'h010, 32'h0,         32'hBEEF_AA21, 1'b0);

    // Backpressure: response held 5 cycles while a second request waits.
    issue_req(1'b0, 3'b010, 10'h010, 32'h0);
    held = rsp_rdata;
    check("bp_first_data", held, 32'hBEEF_AA21);
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 10'h010;
    req_wdata  = 32'h1111_1111;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_rsp_rdata", rsp_rdata,          32'hBEEF_AA21);
      check("bp_rsp_err",   {31'b0, rsp_err},   32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_release_ready", {31'b0, req_ready}, 32'd1);
    check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    xact("lw_no_bp_write", 1'b0, 3'b010, 10'h010, 32'h0, 32'hBEEF_AA21, 1'b0);

    // Asynchronous reset while a response is pending.
    issue_req(1'b0, 3'b010, 10'h010, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_rsp_rdata", rsp_rdata,          32'd0);
    check("arst_rsp_err",   {31'b0, rsp_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    xact("lw_after_rst", 1'b0, 3'b010, 10'h010, 32'h0, 32'hBEEF_AA21, 1'b0);
    xact("lhu_after_rst",1'b0, 3'b101, 10'h012, 32'h0, 32'h0000_BEEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
